fifo_multiport: RTL and testbench

- Parametrised multi-entry FIFO; successor of the single-port register FIFO.
- Accepts up to PUSH_W entries and releases up to POP_W entries per cycle.
- First-word-fall-through head window, occupancy count, programmable almost-full/almost-empty flags and synchronous flush.
- Sits between the fetch buffer and decode/issue in the NPC core, where 2-wide fetch feeds a 1- or 2-wide decoder; clr is driven by redirect/flush.

---
 rtl/fifo_multiport_if.sv | 35 +++
 rtl/fifo_multiport.sv | 85 ++++++++
 tb/tb_fifo_multiport.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/fifo_multiport_if.sv
// Bundle of push/pop handshake and status signals for fifo_multiport.
// The master drives push/pop requests; the slave is the FIFO itself.
interface fifo_multiport_if #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int PUSH_W     = 2,
  parameter int POP_W      = 2
);
  localparam int PUSH_NUM_W = $clog2(PUSH_W + 1);
  localparam int POP_NUM_W  = $clog2(POP_W + 1);
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;

  logic [PUSH_NUM_W-1:0]        push_num;
  logic [PUSH_W*DATA_WIDTH-1:0] push_data;
  logic                         push_ok;
  logic [POP_NUM_W-1:0]         pop_num;
  logic [POP_W*DATA_WIDTH-1:0]  pop_data;
  logic [POP_W-1:0]             pop_valid;
  logic [CNT_W-1:0]             count;
  logic [CNT_W-1:0]             free;
  logic                         full;
  logic                         empty;
  logic                         almost_full;
  logic                         almost_empty;

  modport master (
    output push_num, push_data, pop_num,
    input  push_ok, pop_data, pop_valid, count, free, full, empty, almost_full, almost_empty
  );

  modport slave (
    input  push_num, push_data, pop_num,
    output push_ok, pop_data, pop_valid, count, free, full, empty, almost_full, almost_empty
  );
endinterface

// File: rtl/fifo_multiport.sv
// Multi-entry FIFO: up to PUSH_W writes and POP_W reads per cycle, first-word-fall-through
// head window, registered occupancy with combinational status flags and synchronous flush.
module fifo_multiport #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int PUSH_W     = 2,
  parameter int POP_W      = 2,
  parameter int AFULL_TH   = FIFO_DEPTH - 2,
  parameter int AEMPTY_TH  = 1
) (
  input logic              clk,
  input logic              rst,
  input logic              clr,
  fifo_multiport_if.slave  bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] AFULL_C  = CNT_W'(AFULL_TH);
  localparam logic [CNT_W-1:0] AEMPTY_C = CNT_W'(AEMPTY_TH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q;

  logic [CNT_W-1:0] free;
  logic [CNT_W-1:0] push_cnt;
  logic [CNT_W-1:0] pop_req;
  logic [CNT_W-1:0] popped;
  logic [CNT_W-1:0] pushed;
  logic             do_push;
  logic             flush;

  assign flush    = rst | clr;
  assign free     = DEPTH_C - count_q;
  assign push_cnt = CNT_W'(bus.push_num);
  assign pop_req  = CNT_W'(bus.pop_num);

  // Room is judged on pre-cycle occupancy; a same-cycle pop does not free space.
  assign bus.push_ok = (push_cnt <= free);
  assign do_push     = (bus.push_num != '0) && bus.push_ok;
  assign pushed      = do_push ? push_cnt : '0;
  assign popped      = (pop_req > count_q) ? count_q : pop_req;

  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + PTR_W'(pushed);
      rd_ptr_q <= rd_ptr_q + PTR_W'(popped);
      count_q  <= count_q + pushed - popped;
    end
  end

  // Storage is not reset; writes are suppressed while flushing.
  always_ff @(posedge clk) begin
    if (!flush && do_push) begin
      for (int i = 0; i < PUSH_W; i++) begin
        if (i < int'(bus.push_num)) begin
          mem[wr_ptr_q + PTR_W'(i)] <= bus.push_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  always_comb begin
    bus.pop_data  = '0;
    bus.pop_valid = '0;
    for (int j = 0; j < POP_W; j++) begin
      bus.pop_data[j*DATA_WIDTH +: DATA_WIDTH] = mem[rd_ptr_q + PTR_W'(j)];
      bus.pop_valid[j]                         = (CNT_W'(j) < count_q);
    end
  end

  assign bus.count        = count_q;
  assign bus.free         = free;
  assign bus.full         = (count_q == DEPTH_C);
  assign bus.empty        = (count_q == '0);
  assign bus.almost_full  = (count_q >= AFULL_C);
  assign bus.almost_empty = (count_q <= AEMPTY_C);

endmodule

// File: tb/tb_fifo_multiport.sv
// Directed bench for fifo_multiport: a queue model checked every cycle plus literal
// expectations at the key points of each scenario.
module tb_fifo_multiport;
  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int AF_TH = 6;
  localparam int AE_TH = 1;

  logic clk = 1'b0;
  logic rst;
  logic clr;
  logic check_en;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] model_q[$];

  always #5 clk = ~clk;

  fifo_multiport_if #(
    .DATA_WIDTH(DW),
    .FIFO_DEPTH(DEPTH),
    .PUSH_W    (2),
    .POP_W     (2)
  ) bus ();

  fifo_multiport #(
    .DATA_WIDTH(DW),
    .FIFO_DEPTH(DEPTH),
    .PUSH_W    (2),
    .POP_W     (2),
    .AFULL_TH  (AF_TH),
    .AEMPTY_TH (AE_TH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .clr(clr),
    .bus(bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: compare against the current queue, then apply this cycle's transfer.
  always @(negedge clk) begin
    int sz;
    int pn;
    int on;
    int pop_cnt;
    if (check_en) begin
      sz = model_q.size();
      pn = int'(bus.push_num);
      on = int'(bus.pop_num);
      check("count", 32'(bus.count), 32'(sz));
      check("free", 32'(bus.free), 32'(DEPTH - sz));
      check("full", 32'(bus.full), 32'(sz == DEPTH));
      check("empty", 32'(bus.empty), 32'(sz == 0));
      check("almost_full", 32'(bus.almost_full), 32'(sz >= AF_TH));
      check("almost_empty", 32'(bus.almost_empty), 32'(sz <= AE_TH));
      check("push_ok", 32'(bus.push_ok), 32'(pn <= DEPTH - sz));
      for (int j = 0; j < 2; j++) begin
        check("pop_valid", 32'(bus.pop_valid[j]), 32'(j < sz));
        if (j < sz) check("pop_data", 32'(bus.pop_data[j*DW +: DW]), 32'(model_q[j]));
      end
      if (rst || clr) begin
        model_q.delete();
      end else begin
        if (on > sz) $display("WARN: pop_num %0d exceeds count %0d, clamped", on, sz);
        pop_cnt = (on < sz) ? on : sz;
        for (int k = 0; k < pop_cnt; k++) void'(model_q.pop_front());
        if (pn != 0 && pn <= DEPTH - sz) begin
          for (int k = 0; k < pn; k++) model_q.push_back(bus.push_data[k*DW +: DW]);
        end
      end
    end
  end

  task automatic apply(input int pn, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                       input int on, input logic c, input logic r);
    @(posedge clk);
    #1;
    bus.push_num  = 2'(pn);
    bus.push_data = {d1, d0};
    bus.pop_num   = 2'(on);
    clr           = c;
    rst           = r;
    @(negedge clk);
  endtask

  task automatic idle();
    apply(0, 8'h00, 8'h00, 0, 1'b0, 1'b0);
  endtask

  initial begin
    rst           = 1'b1;
    clr           = 1'b0;
    check_en      = 1'b0;
    bus.push_num  = '0;
    bus.push_data = '0;
    bus.pop_num   = '0;
    @(posedge clk);
    #1;
    check_en = 1'b1;

    // Reset state
    idle();
    check("t1_count", 32'(bus.count), 32'd0);
    check("t1_empty", 32'(bus.empty), 32'd1);
    check("t1_free", 32'(bus.free), 32'd8);
    check("t1_pop_valid", 32'(bus.pop_valid), 32'd0);
    check("t1_almost_empty", 32'(bus.almost_empty), 32'd1);
    check("t1_almost_full", 32'(bus.almost_full), 32'd0);

    // Basic push 2 + 1, then pop 2
    apply(2, 8'h11, 8'h22, 0, 1'b0, 1'b0);
    apply(1, 8'h33, 8'h00, 0, 1'b0, 1'b0);
    idle();
    check("t2_count", 32'(bus.count), 32'd3);
    check("t2_lane0", 32'(bus.pop_data[7:0]), 32'h11);
    check("t2_lane1", 32'(bus.pop_data[15:8]), 32'h22);
    check("t2_pop_valid", 32'(bus.pop_valid), 32'd3);
    apply(0, 8'h00, 8'h00, 2, 1'b0, 1'b0);
    check("t2_pop_lane0", 32'(bus.pop_data[7:0]), 32'h11);
    idle();
    check("t2_after_lane0", 32'(bus.pop_data[7:0]), 32'h33);
    check("t2_after_valid", 32'(bus.pop_valid), 32'd1);
    check("t2_after_count", 32'(bus.count), 32'd1);
    check("t2_after_ae", 32'(bus.almost_empty), 32'd1);

    // Simultaneous push 2 / pop 2 with one entry: pop clamps to 1
    apply(2, 8'h44, 8'h55, 2, 1'b0, 1'b0);
    check("t4_push_ok", 32'(bus.push_ok), 32'd1);
    check("t4_old_head", 32'(bus.pop_data[7:0]), 32'h33);
    idle();
    check("t4_count", 32'(bus.count), 32'd2);
    check("t4_lane0", 32'(bus.pop_data[7:0]), 32'h44);
    check("t4_lane1", 32'(bus.pop_data[15:8]), 32'h55);

    // Fill to 7, rejected over-push, then fill to 8
    apply(2, 8'h60, 8'h61, 0, 1'b0, 1'b0);
    apply(2, 8'h62, 8'h63, 0, 1'b0, 1'b0);
    apply(1, 8'h64, 8'h00, 0, 1'b0, 1'b0);
    apply(2, 8'h65, 8'h66, 0, 1'b0, 1'b0);
    check("t3_count7", 32'(bus.count), 32'd7);
    check("t3_push_ok_rej", 32'(bus.push_ok), 32'd0);
    apply(1, 8'h67, 8'h00, 0, 1'b0, 1'b0);
    check("t3_count_held", 32'(bus.count), 32'd7);
    check("t3_push_ok_one", 32'(bus.push_ok), 32'd1);
    idle();
    check("t3_count8", 32'(bus.count), 32'd8);
    check("t3_full", 32'(bus.full), 32'd1);
    check("t3_almost_full", 32'(bus.almost_full), 32'd1);
    // Push + pop at full: push rejected, pop proceeds
    apply(1, 8'h69, 8'h00, 1, 1'b0, 1'b0);
    check("t3_full_push_ok", 32'(bus.push_ok), 32'd0);
    check("t3_full_head", 32'(bus.pop_data[7:0]), 32'h44);
    idle();
    check("t3_after_count", 32'(bus.count), 32'd7);
    check("t3_after_head", 32'(bus.pop_data[7:0]), 32'h55);

    // Drain (last pop over-requests) then move both pointers to index 7
    repeat (4) apply(0, 8'h00, 8'h00, 2, 1'b0, 1'b0);
    apply(2, 8'h70, 8'h71, 0, 1'b0, 1'b0);
    apply(2, 8'h72, 8'h73, 0, 1'b0, 1'b0);
    apply(0, 8'h00, 8'h00, 2, 1'b0, 1'b0);
    apply(0, 8'h00, 8'h00, 2, 1'b0, 1'b0);
    check("t5_empty", 32'(bus.empty), 32'd0);
    idle();
    check("t5_drained", 32'(bus.empty), 32'd1);
    apply(2, 8'hA0, 8'hA1, 0, 1'b0, 1'b0);
    apply(0, 8'h00, 8'h00, 2, 1'b0, 1'b0);
    check("t5_wrap_lane0", 32'(bus.pop_data[7:0]), 32'hA0);
    check("t5_wrap_lane1", 32'(bus.pop_data[15:8]), 32'hA1);
    check("t5_wrap_valid", 32'(bus.pop_valid), 32'd3);
    idle();
    check("t5_count", 32'(bus.count), 32'd0);

    // Flush via clr, then the same via rst
    for (int pass = 0; pass < 2; pass++) begin
      apply(2, 8'hB0, 8'hB1, 0, 1'b0, 1'b0);
      apply(2, 8'hB2, 8'hB3, 0, 1'b0, 1'b0);
      apply(1, 8'hB4, 8'h00, 0, 1'b0, 1'b0);
      apply(2, 8'hC0, 8'hC1, 1, (pass == 0), (pass == 1));
      check("t6_count_before", 32'(bus.count), 32'd5);
      idle();
      check("t6_count", 32'(bus.count), 32'd0);
      check("t6_empty", 32'(bus.empty), 32'd1);
      check("t6_pop_valid", 32'(bus.pop_valid), 32'd0);
      check("t6_free", 32'(bus.free), 32'd8);
    end

    idle();
    idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
